// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: prioritised next-PC select with interrupt entry/RTI and epc.
// Define PC_RAS_EN to build the return-address stack; without it calls/returns use the ports only.
module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'('h20),
  parameter logic [ADDR_W-1:0] INT_VEC   = ADDR_W'('h0),
  parameter logic [ADDR_W-1:0] INC       = ADDR_W'(1),
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_en,
  input  logic              int_req,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_addr,
  input  logic              call,
  input  logic [ADDR_W-1:0] call_addr,
  input  logic              ret,
  input  logic [ADDR_W-1:0] ret_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] epc,
  output logic              in_isr,
  output logic              int_ack,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);

  // state   | meaning
  // S_RUN   | normal execution, interrupts accepted
  // S_ISR   | inside handler, int_req ignored, ret means RTI
  typedef enum logic {S_RUN, S_ISR} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] pc_nx, epc_nx, seq;
  logic              int_ack_nx;

  assign seq    = pc + INC;
  assign in_isr = (state == S_ISR);

`ifdef PC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_top;
  logic [CNT_W-1:0]  ras_cnt;
  logic              ras_push, ras_pop, ras_unf_nx;

  assign ras_empty = (ras_cnt == '0);
  assign ras_full  = (ras_cnt == FULL_CNT);
`endif

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    epc_nx     = epc;
    int_ack_nx = 1'b0;
`ifdef PC_RAS_EN
    ras_push   = 1'b0;
    ras_pop    = 1'b0;
    ras_unf_nx = 1'b0;
`endif
    if (pc_en) begin
      if (int_req && state == S_RUN) begin
        pc_nx      = INT_VEC;
        epc_nx     = seq;
        state_nx   = S_ISR;
        int_ack_nx = 1'b1;
      end else if (branch_taken) begin
        pc_nx = branch_addr;
      end else if (call) begin
        pc_nx = call_addr;
`ifdef PC_RAS_EN
        ras_push = 1'b1;
`endif
      end else if (ret && state == S_ISR) begin
        pc_nx    = epc;
        state_nx = S_RUN;
      end else if (ret) begin
`ifdef PC_RAS_EN
        ras_pop = 1'b1;
        if (!ras_empty) begin
          pc_nx = ras_mem[ras_top];
        end else begin
          pc_nx      = ret_addr;
          ras_unf_nx = 1'b1;
        end
`else
        pc_nx = ret_addr;
`endif
      end else begin
        pc_nx = seq;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_RUN;
      pc      <= RESET_VEC;
      epc     <= '0;
      int_ack <= 1'b0;
    end else begin
      state   <= state_nx;
      pc      <= pc_nx;
      epc     <= epc_nx;
      int_ack <= int_ack_nx;
    end
  end

`ifdef PC_RAS_EN
  // Circular stack: a push onto a full stack lands on the oldest slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ras_top <= '0;
      ras_cnt <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      ras_ovf <= ras_push && ras_full;
      ras_unf <= ras_unf_nx;
      if (ras_push) begin
        ras_top <= ras_top + 1'b1;
        if (!ras_full) ras_cnt <= ras_cnt + 1'b1;
      end else if (ras_pop && !ras_empty) begin
        ras_top <= ras_top - 1'b1;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ras_push) ras_mem[ras_top + 1'b1] <= seq;
  end
`else
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_ovf   = 1'b0;
  assign ras_unf   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, stall, priority, interrupt entry/RTI, RAS and wrap.
// Stack sections follow the same PC_RAS_EN setting as the design.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, pc_en, int_req, branch_taken, call, ret;
  logic [31:0] branch_addr, call_addr, ret_addr;
  logic [31:0] pc, epc;
  logic        in_isr, int_ack, ras_empty, ras_full, ras_ovf, ras_unf;

  logic        pc_en8;
  logic [7:0]  pc8, epc8;
  logic        in_isr8, int_ack8, ras_empty8, ras_full8, ras_ovf8, ras_unf8;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .pc_en(pc_en), .int_req(int_req),
    .branch_taken(branch_taken), .branch_addr(branch_addr),
    .call(call), .call_addr(call_addr), .ret(ret), .ret_addr(ret_addr),
    .pc(pc), .epc(epc), .in_isr(in_isr), .int_ack(int_ack),
    .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  pc_sequencer #(.ADDR_W(8), .RESET_VEC(8'hFE), .INT_VEC(8'h00), .INC(8'h01)) dut8 (
    .clk(clk), .rst(rst), .pc_en(pc_en8), .int_req(1'b0),
    .branch_taken(1'b0), .branch_addr(8'h00),
    .call(1'b0), .call_addr(8'h00), .ret(1'b0), .ret_addr(8'h00),
    .pc(pc8), .epc(epc8), .in_isr(in_isr8), .int_ack(int_ack8),
    .ras_empty(ras_empty8), .ras_full(ras_full8), .ras_ovf(ras_ovf8), .ras_unf(ras_unf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input logic [31:0] a);
    branch_taken = 1'b1;
    branch_addr  = a;
    step();
    branch_taken = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_en = 1'b1; int_req = 1'b0; branch_taken = 1'b0; call = 1'b0; ret = 1'b0;
    branch_addr = '0; call_addr = '0; ret_addr = '0; pc_en8 = 1'b0;
    #12;
    chk("rst_pc", pc, 32'h20);
    chk("rst_epc", epc, 32'h0);
    chk("rst_isr", {31'd0, in_isr}, 32'd0);
    chk("rst_ack", {31'd0, int_ack}, 32'd0);
    chk("rst_flags", {28'd0, ras_empty, ras_full, ras_ovf, ras_unf}, 32'b1000);
    rst = 1'b0;

    step(); chk("seq1", pc, 32'h21);
    step(); chk("seq2", pc, 32'h22);
    step(); chk("seq3", pc, 32'h23);
    #3 rst = 1'b1;
    #1 chk("async_rst", pc, 32'h20);
    #1 rst = 1'b0;

    // stall holds everything even with a branch pending
    go_to(32'h30); chk("br_30", pc, 32'h30);
    pc_en = 1'b0; branch_taken = 1'b1; branch_addr = 32'h80;
    step(); chk("stall1", pc, 32'h30);
    step(); chk("stall2", pc, 32'h30);
    pc_en = 1'b1;
    step(); chk("stall_rel", pc, 32'h80);
    branch_taken = 1'b0;

    // branch beats call; stack untouched
    branch_taken = 1'b1; branch_addr = 32'h77; call = 1'b1; call_addr = 32'h99;
    step(); chk("br_over_call", pc, 32'h77);
    chk("br_over_call_empty", {31'd0, ras_empty}, 32'd1);
    branch_taken = 1'b0; call = 1'b0;

    // interrupt beats a simultaneous branch, no re-entry, RTI
    go_to(32'h40);
    int_req = 1'b1; branch_taken = 1'b1; branch_addr = 32'h80;
    step();
    chk("int_pc", pc, 32'h0);
    chk("int_epc", epc, 32'h41);
    chk("int_isr", {31'd0, in_isr}, 32'd1);
    chk("int_ack1", {31'd0, int_ack}, 32'd1);
    branch_taken = 1'b0;
    step(); chk("int_ack_drop", {31'd0, int_ack}, 32'd0); chk("isr_seq1", pc, 32'h1);
    step(); chk("isr_seq2", pc, 32'h2);
    step(); chk("isr_seq3", pc, 32'h3); chk("no_nest_epc", epc, 32'h41);
    int_req = 1'b0; ret = 1'b1; ret_addr = 32'hEE;
    step(); chk("rti_pc", pc, 32'h41); chk("rti_isr", {31'd0, in_isr}, 32'd0);
    chk("rti_no_unf", {31'd0, ras_unf}, 32'd0);
    ret = 1'b0;

`ifdef PC_RAS_EN
    go_to(32'h10);
    call = 1'b1; call_addr = 32'h50;
    step(); chk("call1", pc, 32'h50); chk("call1_nonempty", {31'd0, ras_empty}, 32'd0);
    call_addr = 32'h90;
    step(); chk("call2", pc, 32'h90);
    call = 1'b0; ret = 1'b1; ret_addr = 32'hFF;
    step(); chk("ret1", pc, 32'h51);
    step(); chk("ret2", pc, 32'h11); chk("ret2_empty", {31'd0, ras_empty}, 32'd1);
    step(); chk("ret3", pc, 32'hFF); chk("ret3_unf", {31'd0, ras_unf}, 32'd1);
    ret = 1'b0;
    step(); chk("unf_drop", {31'd0, ras_unf}, 32'd0); chk("pc_100", pc, 32'h100);

    call = 1'b1;
    call_addr = 32'h200; step(); chk("n1", pc, 32'h200);
    call_addr = 32'h300; step(); chk("n2_notfull", {31'd0, ras_full}, 32'd0);
    call_addr = 32'h400; step();
    call_addr = 32'h500; step(); chk("n4_full", {31'd0, ras_full}, 32'd1);
    chk("n4_no_ovf", {31'd0, ras_ovf}, 32'd0);
    call_addr = 32'h600; step(); chk("n5_ovf", {31'd0, ras_ovf}, 32'd1); chk("n5_pc", pc, 32'h600);
    call = 1'b0; ret = 1'b1; ret_addr = 32'hFF;
    step(); chk("r1", pc, 32'h501); chk("ovf_drop", {31'd0, ras_ovf}, 32'd0);
    step(); chk("r2", pc, 32'h401);
    step(); chk("r3", pc, 32'h301);
    step(); chk("r4", pc, 32'h201);
    step(); chk("r5", pc, 32'hFF); chk("r5_unf", {31'd0, ras_unf}, 32'd1);
    ret = 1'b0;
`else
    call = 1'b1; call_addr = 32'h50;
    step(); chk("call_plain", pc, 32'h50);
    call = 1'b0; ret = 1'b1; ret_addr = 32'hAB;
    step(); chk("ret_plain", pc, 32'hAB);
    chk("plain_flags", {28'd0, ras_empty, ras_full, ras_ovf, ras_unf}, 32'b1000);
    ret = 1'b0;
`endif

    // reset in the handler drops epc and ISR state
    int_req = 1'b1;
    step(); chk("isr_again", {31'd0, in_isr}, 32'd1);
    int_req = 1'b0;
    #3 rst = 1'b1;
    #1 chk("rst_isr_clr", {31'd0, in_isr}, 32'd0); chk("rst_epc_clr", epc, 32'h0);
    chk("rst8_pc", {24'd0, pc8}, 32'hFE);
    #1 rst = 1'b0;

    pc_en8 = 1'b1;
    step(); chk("w8_ff", {24'd0, pc8}, 32'hFF);
    step(); chk("w8_wrap", {24'd0, pc8}, 32'h00);
    chk("w8_flags", {27'd0, int_ack8, ras_empty8, ras_full8, ras_ovf8, ras_unf8}, 32'b01000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
